imem_loader: RTL and testbench
==============================

# imem_loader

Boot-time program loader that writes the instruction memory, which the core otherwise only reads through its PC-addressed port. It accepts a byte stream with a valid/ready handshake, packs bytes into big-endian 32-bit words, and issues one word write per cycle on the instruction-memory write port. It holds the core's reset asserted until a complete, checksum-verified image has been written.

## Interface
Parameters:
- `MAX_WORDS`, default 64: instruction memory capacity in words; longer images are rejected.
- `ADDR_W`, default 32: width of the byte address driven to instruction memory.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: one-cycle pulse that begins a load; honoured only in IDLE, DONE or ERR.
- `in_valid` in 1: byte-stream valid.
- `in_data` in 8: byte-stream data.
- `in_ready` out 1: loader can accept a byte; a byte transfers on a rising edge with `in_valid && in_ready`.
- `mem_we` out 1: instruction-memory write enable, one cycle per word.
- `mem_addr` out ADDR_W: byte address; word-aligned, starts at 0, steps by 4.
- `mem_wdata` out 32: word to write.
- `cpu_rst` out 1: reset to the program counter, register file and data memory; high except in DONE.
- `busy` out 1: a load is in progress.
- `done` out 1: the image loaded and verified.
- `err` out 1: the load aborted because the length was too large or the checksum did not match.

## Operation
Stream format, in order:
- Byte 1: N[15:8].
- Byte 2: N[7:0].
- N×4 payload bytes, each word MSB first.
- 1 checksum byte: XOR of every preceding byte, including the length bytes.

FSM states: IDLE, LEN_HI, LEN_LO, DATA, WRITE, CHECK, DONE, ERR.
- IDLE: `start` → LEN_HI.
- LEN_HI: accept byte → LEN_LO.
- LEN_LO: accept byte, then:
  - N > MAX_WORDS → ERR;
  - N == 0 → CHECK;
  - otherwise → DATA.
- DATA: accept bytes into a shift register; byte counter runs 0..3; the 4th byte → WRITE.
- WRITE: `mem_we`=1 for exactly one cycle with the current `mem_addr`/`mem_wdata`. Next cycle `mem_addr` += 4 and the remaining-word count decrements. Words remain → DATA; none remain → CHECK.
- CHECK: accept one byte. Byte equals the running XOR → DONE; otherwise → ERR.
- DONE: `done`=1 and `cpu_rst`=0; stays until `start` → LEN_HI.
- ERR: `err`=1 and `cpu_rst`=1; stays until `start` → LEN_HI.

Output rules:
- `in_ready` = 1 only in LEN_HI, LEN_LO, DATA and CHECK.
- `busy` = 1 in LEN_HI through CHECK.
- `start` is ignored while `busy`.
- On restart, `mem_addr`, the byte counter and the XOR accumulator clear to 0, and `done`/`err` drop in the same cycle `busy` rises.

Width rules:
- Word counter is 16 bits. `mem_addr` = word index × 4, zero-extended to ADDR_W.
- XOR accumulator is 8 bits.

## Timing
- Reset (asynchronous, any state): state=IDLE; `in_ready`, `mem_we`, `busy`, `done`, `err` = 0; `mem_addr`=0; `mem_wdata`=0; `cpu_rst`=1.
- Reset in the middle of a load abandons it. A partial image may remain in memory, but the core stays in reset.
- Latency: `mem_we` asserts in the cycle after the 4th byte of a word is accepted.
- Minimum load time: 3 + 5N cycles of accepted or write activity after `start`.
- Gaps in `in_valid` stall the FSM with no state change. `in_data` is ignored when no transfer occurs.
- `cpu_rst` falls in the cycle DONE is entered. It rises in the cycle `start` is accepted from DONE.
- `mem_we` never asserts outside WRITE. It never asserts for N=0 or for rejected lengths.

## Structure
- Shared package / include file (`mips_defs`): FSM state encodings for `imem_loader` and the constant `WORD_BYTES`=4.
- One sub-module, `imem_word_packer`: an 8-to-32 shift register with a 2-bit byte counter and a `word_ready` pulse.
- Top-level integration: `cpu_rst` ORed with system `rst` into the core's reset; `mem_we`/`mem_addr`/`mem_wdata` drive a new write port on instruction memory.

## Test plan
- Normal load: `start`, then bytes 00 02 20 08 00 05 20 09 00 0C 0A → writes (0x0, 0x20080005), (0x4, 0x2009000C); `done`=1; `cpu_rst`=0.
- Empty image: bytes 00 00 00 → no `mem_we`; `done`=1.
- Bad checksum: the normal-load stream with a final byte of 0x0B → both writes occur; `err`=1; `cpu_rst` stays 1.
- Oversize: with MAX_WORDS=64, bytes 00 41 → ERR immediately after the 2nd byte; `in_ready`=0; no writes.
- Handshake: the normal-load stream with random `in_valid` gaps → identical writes and result.
- Stress: `start` pulses while `busy` are ignored; async `rst` after 6 bytes → IDLE with `cpu_rst`=1; a fresh load then succeeds; `start` from DONE reasserts `cpu_rst` and reloads the image.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// Shared definitions for the boot-time instruction-memory loader:
// FSM state encoding, word geometry and state-decode helpers.
package imem_loader_pkg;

  localparam int WORD_BYTES = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN_HI,
    ST_LEN_LO,
    ST_DATA,
    ST_WRITE,
    ST_CHECK,
    ST_DONE,
    ST_ERR
  } state_t;

  // States that consume a byte from the input stream.
  function automatic logic takes_byte(state_t s);
    return (s == ST_LEN_HI) || (s == ST_LEN_LO) || (s == ST_DATA) || (s == ST_CHECK);
  endfunction

  function automatic logic is_busy(state_t s);
    return (s == ST_LEN_HI) || (s == ST_LEN_LO) || (s == ST_DATA) ||
           (s == ST_WRITE)  || (s == ST_CHECK);
  endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input handshake plus the instruction-memory write port.
// The loader is the slave of the stream and drives the memory write side.
interface imem_loader_if #(
  parameter int ADDR_W = 32
);
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;

  modport master (
    output in_valid, in_data,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/imem_loader_word_packer.sv
// Big-endian byte-to-word packer: shifts bytes in MSB first and flags the
// byte that completes a word, presenting the full word combinationally.
module imem_word_packer
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        shift_en,
  input  logic [7:0]  byte_in,
  output logic [31:0] word_next,
  output logic        word_ready
);
  localparam int CNT_W = $clog2(WORD_BYTES);

  logic [8*(WORD_BYTES-1)-1:0] shift_reg;
  logic [CNT_W-1:0]            cnt_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_reg <= '0;
      cnt_reg   <= '0;
    end else if (clr) begin
      shift_reg <= '0;
      cnt_reg   <= '0;
    end else if (shift_en) begin
      shift_reg <= {shift_reg[8*(WORD_BYTES-2)-1:0], byte_in};
      cnt_reg   <= cnt_reg + 1'b1;
    end
  end

  // The counter wraps on its own after the last byte of a word.
  assign word_next  = {shift_reg, byte_in};
  assign word_ready = shift_en && (cnt_reg == CNT_W'(WORD_BYTES - 1));
endmodule

// File: rtl/imem_loader.sv
// Boot loader: parses a length-prefixed, XOR-checksummed byte stream, writes
// one 32-bit word per cycle into instruction memory, and holds the core in reset until verified.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int MAX_WORDS = 64,
  parameter int ADDR_W    = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  imem_loader_if.slave bus,
  output logic         cpu_rst,
  output logic         busy,
  output logic         done,
  output logic         err
);
  state_t      state_reg;
  state_t      state_next;
  logic        in_ready_reg;
  logic        mem_we_reg;
  logic [31:0] mem_wdata_reg;
  logic [7:0]  len_hi_reg;
  logic [7:0]  xor_reg;
  logic [15:0] words_left_reg;
  logic [15:0] word_idx_reg;

  logic        accept;
  logic        start_accept;
  logic [15:0] len_full;
  logic        len_too_big;
  logic        pack_shift;
  logic        word_ready;
  logic [31:0] word_next;

  assign accept       = bus.in_valid && in_ready_reg;
  assign start_accept = start && !is_busy(state_reg);
  assign len_full     = {len_hi_reg, bus.in_data};
  assign len_too_big  = {1'b0, len_full} > 17'(MAX_WORDS);
  assign pack_shift   = accept && (state_reg == ST_DATA);

  imem_word_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .clr        (start_accept),
    .shift_en   (pack_shift),
    .byte_in    (bus.in_data),
    .word_next  (word_next),
    .word_ready (word_ready)
  );

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE, ST_DONE, ST_ERR: if (start) state_next = ST_LEN_HI;
      ST_LEN_HI: if (accept) state_next = ST_LEN_LO;
      ST_LEN_LO: begin
        if (accept) begin
          if (len_too_big)          state_next = ST_ERR;
          else if (len_full == '0)  state_next = ST_CHECK;
          else                      state_next = ST_DATA;
        end
      end
      ST_DATA:  if (accept && word_ready) state_next = ST_WRITE;
      ST_WRITE: state_next = (words_left_reg == 16'd1) ? ST_CHECK : ST_DATA;
      ST_CHECK: begin
        if (accept) state_next = (bus.in_data == xor_reg) ? ST_DONE : ST_ERR;
      end
      default:  state_next = ST_IDLE;
    endcase
  end

  // Status outputs are registered from the next state so they change
  // in the same cycle the FSM enters its new state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= ST_IDLE;
      in_ready_reg   <= 1'b0;
      mem_we_reg     <= 1'b0;
      mem_wdata_reg  <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      err            <= 1'b0;
      cpu_rst        <= 1'b1;
      len_hi_reg     <= '0;
      xor_reg        <= '0;
      words_left_reg <= '0;
      word_idx_reg   <= '0;
    end else begin
      state_reg    <= state_next;
      in_ready_reg <= takes_byte(state_next);
      mem_we_reg   <= (state_next == ST_WRITE);
      busy         <= is_busy(state_next);
      done         <= (state_next == ST_DONE);
      err          <= (state_next == ST_ERR);
      cpu_rst      <= (state_next != ST_DONE);

      if (start_accept) begin
        xor_reg      <= '0;
        word_idx_reg <= '0;
      end else if (accept && state_reg != ST_CHECK) begin
        xor_reg <= xor_reg ^ bus.in_data;
      end

      if (accept && state_reg == ST_LEN_HI) len_hi_reg     <= bus.in_data;
      if (accept && state_reg == ST_LEN_LO) words_left_reg <= len_full;
      if (pack_shift && word_ready)         mem_wdata_reg  <= word_next;

      if (state_reg == ST_WRITE) begin
        word_idx_reg   <= word_idx_reg + 16'd1;
        words_left_reg <= words_left_reg - 16'd1;
      end
    end
  end

  assign bus.in_ready  = in_ready_reg;
  assign bus.mem_we    = mem_we_reg;
  assign bus.mem_wdata = mem_wdata_reg;
  assign bus.mem_addr  = ADDR_W'({word_idx_reg, 2'b00});
endmodule

// File: tb/tb_imem_loader.sv
// Randomized self-checking bench for imem_loader: a byte-stream reference
// model predicts writes, write timing and the final verdict of every load.
module tb_imem_loader;
  localparam int MAX_WORDS = 64;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic cpu_rst, busy, done, err;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  imem_loader_if #(.ADDR_W(32)) bus ();

  imem_loader #(.MAX_WORDS(MAX_WORDS), .ADDR_W(32)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .bus     (bus),
    .cpu_rst (cpu_rst),
    .busy    (busy),
    .done    (done),
    .err     (err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0]  stim_q[$];
  int          accept_cyc_q[$];
  logic [31:0] exp_addr_q[$], exp_data_q[$];
  int          exp_idx_q[$];
  logic [31:0] obs_addr_q[$], obs_data_q[$];
  int          obs_cyc_q[$];
  bit          exp_done, exp_err;
  int          exp_consume;

  always @(negedge clk) begin
    if (bus.mem_we) begin
      obs_addr_q.push_back(bus.mem_addr);
      obs_data_q.push_back(bus.mem_wdata);
      obs_cyc_q.push_back(cyc);
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  // Reference: interpret the stream by its format rules.
  task automatic model();
    int n;
    logic [7:0] x;
    exp_addr_q.delete(); exp_data_q.delete(); exp_idx_q.delete();
    exp_done = 1'b0;
    exp_err  = 1'b0;
    n = int'({stim_q[0], stim_q[1]});
    if (n > MAX_WORDS) begin
      exp_err     = 1'b1;
      exp_consume = 2;
      return;
    end
    x = 8'h00;
    for (int i = 0; i < 2 + 4 * n; i++) x ^= stim_q[i];
    for (int w = 0; w < n; w++) begin
      exp_addr_q.push_back(32'(4 * w));
      exp_data_q.push_back({stim_q[2+4*w], stim_q[3+4*w], stim_q[4+4*w], stim_q[5+4*w]});
      exp_idx_q.push_back(2 + 4 * w + 3);
    end
    exp_consume = 3 + 4 * n;
    if (stim_q[2+4*n] == x) exp_done = 1'b1;
    else                    exp_err  = 1'b1;
  endtask

  task automatic build_image(input int n, input bit corrupt);
    logic [7:0] x;
    logic [7:0] b;
    stim_q.delete();
    stim_q.push_back(8'(n >> 8));
    stim_q.push_back(8'(n));
    if (n > MAX_WORDS) begin
      for (int i = 0; i < 4; i++) stim_q.push_back(8'($urandom));
      return;
    end
    x = stim_q[0] ^ stim_q[1];
    for (int i = 0; i < 4 * n; i++) begin
      b = 8'($urandom);
      stim_q.push_back(b);
      x ^= b;
    end
    if (corrupt) x ^= 8'($urandom_range(1, 255));
    stim_q.push_back(x);
  endtask

  // Pulses start, then offers nsend bytes with random gaps; returns on the
  // falling edge right after the last accepted byte.
  task automatic drive(input int nsend, input int gap_pct, input bit noise);
    int idx = 0;
    int wait_cnt = 0;
    obs_addr_q.delete(); obs_data_q.delete(); obs_cyc_q.delete();
    accept_cyc_q.delete();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("start_busy", 32'(busy), 32'd1);
    chk("start_done", 32'(done), 32'd0);
    chk("start_err", 32'(err), 32'd0);
    chk("start_cpu_rst", 32'(cpu_rst), 32'd1);
    chk("start_addr", bus.mem_addr, 32'd0);
    chk("start_ready", 32'(bus.in_ready), 32'd1);
    while (idx < nsend) begin
      start = noise && ($urandom_range(0, 9) == 0);
      if (int'($urandom_range(0, 99)) < gap_pct) begin
        bus.in_valid = 1'b0;
        bus.in_data  = 8'($urandom);
      end else begin
        bus.in_valid = 1'b1;
        bus.in_data  = stim_q[idx];
      end
      if (bus.in_valid && bus.in_ready) begin
        accept_cyc_q.push_back(cyc + 1);
        idx++;
        wait_cnt = 0;
      end else if (++wait_cnt > 200) begin
        chk("byte_timeout", 32'(idx), 32'(nsend));
        break;
      end
      @(negedge clk);
    end
    start        = 1'b0;
    bus.in_valid = 1'b0;
  endtask

  task automatic check_load(input string name, input int gap_pct);
    chk("wr_count", 32'(obs_addr_q.size()), 32'(exp_addr_q.size()));
    for (int i = 0; i < exp_addr_q.size() && i < obs_addr_q.size(); i++) begin
      chk("wr_addr", obs_addr_q[i], exp_addr_q[i]);
      chk("wr_data", obs_data_q[i], exp_data_q[i]);
      if (exp_idx_q[i] < accept_cyc_q.size())
        chk("wr_latency", 32'(obs_cyc_q[i]), 32'(accept_cyc_q[exp_idx_q[i]]));
    end
    chk("end_done", 32'(done), 32'(exp_done));
    chk("end_err", 32'(err), 32'(exp_err));
    chk("end_cpu_rst", 32'(cpu_rst), 32'(!exp_done));
    chk("end_busy", 32'(busy), 32'd0);
    chk("end_ready", 32'(bus.in_ready), 32'd0);
    chk("end_we", 32'(bus.mem_we), 32'd0);
    @(negedge clk);
    chk("hold_done", 32'(done), 32'(exp_done));
    $display("load %s: bytes=%0d gaps=%0d%% writes=%0d done=%0d err=%0d",
             name, exp_consume, gap_pct, obs_addr_q.size(), done, err);
  endtask

  task automatic run_load(input string name, input int gap_pct, input bit noise);
    model();
    drive(exp_consume, gap_pct, noise);
    check_load(name, gap_pct);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst          = 1'b1;
    start        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(bus.in_ready), 32'd0);
    chk("rst_we", 32'(bus.mem_we), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_addr", bus.mem_addr, 32'd0);
    chk("rst_wdata", bus.mem_wdata, 32'd0);
    chk("rst_cpu_rst", 32'(cpu_rst), 32'd1);
    rst = 1'b0;

    stim_q = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h20, 8'h09, 8'h00, 8'h0C, 8'h0A};
    run_load("normal", 0, 1'b0);
    stim_q = '{8'h00, 8'h00, 8'h00};
    run_load("empty", 0, 1'b0);
    stim_q = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h20, 8'h09, 8'h00, 8'h0C, 8'h0B};
    run_load("bad_sum", 0, 1'b0);
    stim_q = '{8'h00, 8'h41};
    run_load("oversize", 0, 1'b0);
    stim_q = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h20, 8'h09, 8'h00, 8'h0C, 8'h0A};
    run_load("gaps", 40, 1'b1);

    // Abandon a load part-way with an asynchronous reset.
    drive(6, 20, 1'b1);
    chk("mid_we", 32'(bus.mem_we), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_cpu_rst", 32'(cpu_rst), 32'd1);
    chk("mid_rst_we", 32'(bus.mem_we), 32'd0);
    chk("mid_rst_addr", bus.mem_addr, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    $display("load mid_reset: bytes=6 aborted busy=%0d cpu_rst=%0d", busy, cpu_rst);
    run_load("after_reset", 25, 1'b1);

    build_image(MAX_WORDS, 1'b0);
    run_load("max_words", 10, 1'b1);
    build_image(MAX_WORDS + 1, 1'b0);
    run_load("max_plus_one", 10, 1'b1);

    for (int t = 0; t < 20; t++) begin
      case ($urandom_range(0, 9))
        0:       n = int'($urandom_range(MAX_WORDS + 1, 65535));
        1:       n = int'($urandom_range(MAX_WORDS - 2, MAX_WORDS));
        default: n = int'($urandom_range(0, 6));
      endcase
      build_image(n, $urandom_range(0, 3) == 0);
      run_load($sformatf("rand%0d_n%0d", t, n), int'($urandom_range(0, 50)), 1'b1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
